// File: rtl/hazard_sb.sv
// N-lane hazard unit with forwarding selects, stall/flush generation and a register scoreboard for long-latency ops.
// Optional per-hazard cycle counters are enabled with `define HAZARD_PERF_EN.
module hazard_sb #(
    parameter int unsigned LANES = 2,
    parameter int unsigned NREG  = 32,
    parameter int unsigned RW    = 5,
    parameter int unsigned LW    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enableD,
    input  logic                  PCSrcE,
    input  logic                  Stall_miss,
    input  logic [LANES*RW-1:0]   Rs1D,
    input  logic [LANES*RW-1:0]   Rs2D,
    input  logic [LANES*RW-1:0]   Rs1E,
    input  logic [LANES*RW-1:0]   Rs2E,
    input  logic [LANES*RW-1:0]   RdE,
    input  logic [LANES-1:0]      ResultSrcE0,
    input  logic [LANES-1:0]      EcallE,
    input  logic [LANES-1:0]      EcallM,
    input  logic [LANES-1:0]      LongIssueE,
    input  logic [LANES*RW-1:0]   RdM,
    input  logic [LANES*RW-1:0]   RdW,
    input  logic [LANES-1:0]      RegWriteM,
    input  logic [LANES-1:0]      RegWriteW,
    input  logic                  LongDoneValid,
    input  logic [RW-1:0]         LongDoneRd,
    output logic [LANES*2-1:0]    ForwardAE,
    output logic [LANES*2-1:0]    ForwardBE,
    output logic [LANES*LW-1:0]   FwdLaneAE,
    output logic [LANES*LW-1:0]   FwdLaneBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  StallW,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [RW:0]           BusyCount
`ifdef HAZARD_PERF_EN
    ,
    input  logic                  PerfClr,
    output logic [31:0]           PerfLoad,
    output logic [31:0]           PerfEcall,
    output logic [31:0]           PerfSb,
    output logic [31:0]           PerfMiss
`endif
);

    localparam int unsigned CW     = RW + 1;
    localparam int unsigned A0_REG = 10;

    logic [NREG-1:0] busyQ;
    logic [NREG-1:0] busyNext;
    logic [CW-1:0]   countNext;
    logic            loadHit;
    logic            ecallSrc;
    logic            sbHit;
    logic            loadHazard;
    logic            ecallHazard;
    logic            sbHazard;

    // Forward select for one E source: M beats W, youngest lane within a stage wins.
    function automatic logic [LW+1:0] fwdSel(input logic [RW-1:0] src);
        logic [1:0]    sel;
        logic [LW-1:0] lane;
        sel  = 2'b00;
        lane = '0;
        if (src != '0) begin
            for (int l = 0; l < LANES; l++) begin
                if (RegWriteW[l] && (RdW[l*RW +: RW] == src)) begin
                    sel  = 2'b01;
                    lane = LW'(l);
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (RegWriteM[l] && (RdM[l*RW +: RW] == src)) begin
                    sel  = 2'b10;
                    lane = LW'(l);
                end
            end
        end
        return {sel, lane};
    endfunction

    always_comb begin
        ForwardAE = '0;
        ForwardBE = '0;
        FwdLaneAE = '0;
        FwdLaneBE = '0;
        for (int e = 0; e < LANES; e++) begin
            {ForwardAE[e*2 +: 2], FwdLaneAE[e*LW +: LW]} = fwdSel(Rs1E[e*RW +: RW]);
            {ForwardBE[e*2 +: 2], FwdLaneBE[e*LW +: LW]} = fwdSel(Rs2E[e*RW +: RW]);
        end
    end

    // Source-side hazard detection across every D lane.
    always_comb begin
        loadHit  = 1'b0;
        ecallSrc = 1'b0;
        sbHit    = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if ((Rs1D[k*RW +: RW] == RW'(A0_REG)) || (Rs2D[k*RW +: RW] == RW'(A0_REG))) begin
                ecallSrc = 1'b1;
            end
            if ((Rs1D[k*RW +: RW] != '0) && busyQ[Rs1D[k*RW +: RW]]) begin
                sbHit = 1'b1;
            end
            if ((Rs2D[k*RW +: RW] != '0) && busyQ[Rs2D[k*RW +: RW]]) begin
                sbHit = 1'b1;
            end
            for (int l = 0; l < LANES; l++) begin
                if (ResultSrcE0[l] && (RdE[l*RW +: RW] != '0) &&
                    ((RdE[l*RW +: RW] == Rs1D[k*RW +: RW]) ||
                     (RdE[l*RW +: RW] == Rs2D[k*RW +: RW]))) begin
                    loadHit = 1'b1;
                end
            end
        end
    end

    assign loadHazard  = enableD & loadHit;
    assign ecallHazard = enableD & (|(EcallE | EcallM)) & ecallSrc;
    assign sbHazard    = enableD & sbHit;

    assign StallF = loadHazard | ecallHazard | sbHazard | Stall_miss;
    assign StallD = StallF;
    assign StallE = Stall_miss;
    assign StallM = Stall_miss;
    assign StallW = Stall_miss;
    assign FlushD = ~Stall_miss & PCSrcE;
    assign FlushE = ~Stall_miss & (PCSrcE | loadHazard | ecallHazard | sbHazard);

    // Completion clears first so a same-cycle issue to that register wins.
    always_comb begin
        busyNext = busyQ;
        if (LongDoneValid) begin
            busyNext[LongDoneRd] = 1'b0;
        end
        if (!Stall_miss) begin
            for (int l = 0; l < LANES; l++) begin
                if (LongIssueE[l] && (RdE[l*RW +: RW] != '0)) begin
                    busyNext[RdE[l*RW +: RW]] = 1'b1;
                end
            end
        end
        busyNext[0] = 1'b0;
    end

    always_comb begin
        countNext = '0;
        for (int r = 0; r < NREG; r++) begin
            countNext = countNext + CW'(busyNext[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyQ     <= '0;
            BusyCount <= '0;
        end else begin
            busyQ     <= busyNext;
            BusyCount <= countNext;
        end
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] satInc(input logic [31:0] v, input logic hit);
        return (hit && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating per-cause cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PerfLoad  <= '0;
            PerfEcall <= '0;
            PerfSb    <= '0;
            PerfMiss  <= '0;
        end else if (PerfClr) begin
            PerfLoad  <= '0;
            PerfEcall <= '0;
            PerfSb    <= '0;
            PerfMiss  <= '0;
        end else begin
            PerfLoad  <= satInc(PerfLoad, loadHazard);
            PerfEcall <= satInc(PerfEcall, ecallHazard);
            PerfSb    <= satInc(PerfSb, sbHazard);
            PerfMiss  <= satInc(PerfMiss, Stall_miss);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Randomized self-checking bench for hazard_sb against a rule-level reference model.
module tb_hazard_sb;

    localparam int LANES = 2;
    localparam int NREG  = 32;
    localparam int RW    = 5;
    localparam int LW    = 1;

    logic                clk;
    logic                rst_n;
    logic                enableD, PCSrcE, Stall_miss;
    logic [LANES*RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [LANES-1:0]    ResultSrcE0, EcallE, EcallM, LongIssueE, RegWriteM, RegWriteW;
    logic                LongDoneValid;
    logic [RW-1:0]       LongDoneRd;
    logic [LANES*2-1:0]  ForwardAE, ForwardBE;
    logic [LANES*LW-1:0] FwdLaneAE, FwdLaneBE;
    logic                StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [RW:0]         BusyCount;
`ifdef HAZARD_PERF_EN
    logic                PerfClr;
    logic [31:0]         PerfLoad, PerfEcall, PerfSb, PerfMiss;
    logic [31:0]         mLoad, mEcall, mSb, mMiss;
`endif

    int nChecks = 0;
    int nErrors = 0;
    bit mBusy [NREG];

    hazard_sb #(.LANES(LANES), .NREG(NREG), .RW(RW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .enableD(enableD), .PCSrcE(PCSrcE), .Stall_miss(Stall_miss),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .EcallE(EcallE), .EcallM(EcallM), .LongIssueE(LongIssueE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LongDoneValid(LongDoneValid), .LongDoneRd(LongDoneRd),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .FwdLaneAE(FwdLaneAE), .FwdLaneBE(FwdLaneBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .BusyCount(BusyCount)
`ifdef HAZARD_PERF_EN
        , .PerfClr(PerfClr), .PerfLoad(PerfLoad), .PerfEcall(PerfEcall), .PerfSb(PerfSb), .PerfMiss(PerfMiss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Youngest-first search: first hit in M, else first hit in W.
    function automatic logic [2+LW-1:0] fwdModel(input logic [RW-1:0] s);
        if (s == '0) return '0;
        for (int l = LANES - 1; l >= 0; l--)
            if (RegWriteM[l] && RdM[l*RW +: RW] == s) return {2'b10, LW'(l)};
        for (int l = LANES - 1; l >= 0; l--)
            if (RegWriteW[l] && RdW[l*RW +: RW] == s) return {2'b01, LW'(l)};
        return '0;
    endfunction

    function automatic bit readsReg(input logic [RW-1:0] r);
        for (int k = 0; k < LANES; k++)
            if (Rs1D[k*RW +: RW] == r || Rs2D[k*RW +: RW] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Returns {load, ecall, sb} hazard terms.
    function automatic logic [2:0] hazModel();
        bit lh = 0, eh = 0, sh = 0;
        for (int l = 0; l < LANES; l++)
            if (ResultSrcE0[l] && RdE[l*RW +: RW] != '0 && readsReg(RdE[l*RW +: RW])) lh = 1;
        if ((EcallE | EcallM) != '0 && readsReg(RW'(10))) eh = 1;
        for (int r = 1; r < NREG; r++)
            if (mBusy[r] && readsReg(RW'(r))) sh = 1;
        return {enableD & lh, enableD & eh, enableD & sh};
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int r = 0; r < NREG; r++) c += int'(mBusy[r]);
        return c;
    endfunction

    task automatic clearInputs();
        enableD = 0; PCSrcE = 0; Stall_miss = 0;
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE0 = '0; EcallE = '0; EcallM = '0; LongIssueE = '0;
        RegWriteM = '0; RegWriteW = '0; LongDoneValid = 0; LongDoneRd = '0;
`ifdef HAZARD_PERF_EN
        PerfClr = 0;
`endif
    endtask

    function automatic logic [RW-1:0] pickReg();
        return RW'($urandom_range(0, 11));
    endfunction

    task automatic driveRandom();
        enableD    = ($urandom_range(0, 7) != 0);
        PCSrcE     = ($urandom_range(0, 7) == 0);
        Stall_miss = ($urandom_range(0, 7) == 0);
        for (int l = 0; l < LANES; l++) begin
            Rs1D[l*RW +: RW] = pickReg(); Rs2D[l*RW +: RW] = pickReg();
            Rs1E[l*RW +: RW] = pickReg(); Rs2E[l*RW +: RW] = pickReg();
            RdE[l*RW +: RW]  = pickReg(); RdM[l*RW +: RW]  = pickReg(); RdW[l*RW +: RW] = pickReg();
            ResultSrcE0[l] = ($urandom_range(0, 3) == 0);
            EcallE[l]      = ($urandom_range(0, 15) == 0);
            EcallM[l]      = ($urandom_range(0, 15) == 0);
            LongIssueE[l]  = ($urandom_range(0, 5) == 0);
            RegWriteM[l]   = ($urandom_range(0, 1) == 0);
            RegWriteW[l]   = ($urandom_range(0, 1) == 0);
        end
        LongDoneValid = ($urandom_range(0, 3) == 0);
        LongDoneRd    = pickReg();
`ifdef HAZARD_PERF_EN
        PerfClr = ($urandom_range(0, 31) == 0);
`endif
    endtask

    // Let inputs settle, then compare every combinational output with the model.
    task automatic settle();
        logic [LANES*2-1:0]  eFA, eFB;
        logic [LANES*LW-1:0] eLA, eLB;
        logic [2:0]          hz;
        logic                st;
        #1;
        for (int e = 0; e < LANES; e++) begin
            {eFA[e*2 +: 2], eLA[e*LW +: LW]} = fwdModel(Rs1E[e*RW +: RW]);
            {eFB[e*2 +: 2], eLB[e*LW +: LW]} = fwdModel(Rs2E[e*RW +: RW]);
        end
        hz = hazModel();
        st = Stall_miss;
        checkVal("ForwardAE", 64'(ForwardAE), 64'(eFA));
        checkVal("ForwardBE", 64'(ForwardBE), 64'(eFB));
        checkVal("FwdLaneAE", 64'(FwdLaneAE), 64'(eLA));
        checkVal("FwdLaneBE", 64'(FwdLaneBE), 64'(eLB));
        checkVal("StallF", 64'(StallF), 64'(st | (|hz)));
        checkVal("StallD", 64'(StallD), 64'(st | (|hz)));
        checkVal("StallEMW", 64'({StallE, StallM, StallW}), 64'({st, st, st}));
        checkVal("FlushD", 64'(FlushD), 64'(!st & PCSrcE));
        checkVal("FlushE", 64'(FlushE), 64'(!st & (PCSrcE | (|hz))));
    endtask

    // Apply the clock edge to the model and check registered state afterwards.
    task automatic advance();
        bit nb [NREG];
        logic [2:0] hz;
        hz = hazModel();
        for (int r = 0; r < NREG; r++) begin
            bit setIt = 0;
            for (int l = 0; l < LANES; l++)
                if (LongIssueE[l] && !Stall_miss && int'(RdE[l*RW +: RW]) == r) setIt = 1;
            if (r == 0) nb[r] = 0;
            else if (setIt) nb[r] = 1;
            else if (LongDoneValid && int'(LongDoneRd) == r) nb[r] = 0;
            else nb[r] = mBusy[r];
        end
`ifdef HAZARD_PERF_EN
        if (PerfClr) begin
            mLoad = 0; mEcall = 0; mSb = 0; mMiss = 0;
        end else begin
            if (hz[2] && mLoad != 32'hFFFF_FFFF) mLoad++;
            if (hz[1] && mEcall != 32'hFFFF_FFFF) mEcall++;
            if (hz[0] && mSb != 32'hFFFF_FFFF) mSb++;
            if (Stall_miss && mMiss != 32'hFFFF_FFFF) mMiss++;
        end
`endif
        @(posedge clk);
        mBusy = nb;
        @(negedge clk);
        checkVal("BusyCount", 64'(BusyCount), 64'(modelCount()));
`ifdef HAZARD_PERF_EN
        checkVal("PerfLoad", 64'(PerfLoad), 64'(mLoad));
        checkVal("PerfEcall", 64'(PerfEcall), 64'(mEcall));
        checkVal("PerfSb", 64'(PerfSb), 64'(mSb));
        checkVal("PerfMiss", 64'(PerfMiss), 64'(mMiss));
`endif
    endtask

    task automatic modelReset();
        for (int r = 0; r < NREG; r++) mBusy[r] = 0;
`ifdef HAZARD_PERF_EN
        mLoad = 0; mEcall = 0; mSb = 0; mMiss = 0;
`endif
    endtask

    initial begin
        rst_n = 0;
        clearInputs();
        modelReset();
        #3;
        checkVal("rstBusyCount", 64'(BusyCount), 64'(0));
        settle();
        @(negedge clk);
        rst_n = 1;

        // Forwarding priority: M lane1 beats W lane0.
        clearInputs();
        RdM[1*RW +: RW] = 5; RegWriteM = 2'b10;
        RdW[0 +: RW] = 5;    RegWriteW = 2'b01;
        Rs1E[0 +: RW] = 5;
        settle();
        checkVal("fwdM", 64'(ForwardAE[1:0]), 64'(2'b10));
        checkVal("fwdLaneM", 64'(FwdLaneAE[0]), 64'(1));
        Rs1E[0 +: RW] = 0;
        settle();
        checkVal("fwdZero", 64'(ForwardAE[1:0]), 64'(0));
        checkVal("fwdLaneZero", 64'(FwdLaneAE[0]), 64'(0));
        advance();

        // Load-use then load moved to M.
        clearInputs();
        enableD = 1; ResultSrcE0 = 2'b01; RdE[0 +: RW] = 7; Rs2D[1*RW +: RW] = 7;
        settle();
        checkVal("loadStallD", 64'(StallD), 64'(1));
        checkVal("loadFlushE", 64'(FlushE), 64'(1));
        checkVal("loadFlushD", 64'(FlushD), 64'(0));
        advance();
        ResultSrcE0 = '0; RdE = '0; RdM[0 +: RW] = 7; RegWriteM = 2'b01;
        settle();
        checkVal("loadGoneStallD", 64'(StallD), 64'(0));
        advance();

        // Long op on x9 interlocks D until completion.
        clearInputs();
        LongIssueE = 2'b10; RdE[1*RW +: RW] = 9;
        settle();
        advance();
        checkVal("longBusy", 64'(BusyCount), 64'(1));
        clearInputs();
        enableD = 1; Rs1D[0 +: RW] = 9;
        repeat (3) begin
            settle();
            checkVal("sbStallD", 64'(StallD), 64'(1));
            advance();
        end
        LongDoneValid = 1; LongDoneRd = 9;
        settle();
        checkVal("sbStallDoneCycle", 64'(StallD), 64'(1));
        advance();
        LongDoneValid = 0;
        settle();
        checkVal("sbStallCleared", 64'(StallD), 64'(0));
        advance();

        // Same-cycle completion and reissue of x9 keeps it busy.
        clearInputs();
        LongIssueE = 2'b01; RdE[0 +: RW] = 9;
        settle(); advance();
        LongDoneValid = 1; LongDoneRd = 9;
        settle(); advance();
        checkVal("setWinsBusy", 64'(BusyCount), 64'(1));
        LongIssueE = '0;
        settle(); advance();
        checkVal("doneClears", 64'(BusyCount), 64'(0));

        // Redirect under AXI miss versus free-running.
        clearInputs();
        PCSrcE = 1; Stall_miss = 1;
        settle();
        checkVal("missFlushD", 64'(FlushD), 64'(0));
        checkVal("missFlushE", 64'(FlushE), 64'(0));
        checkVal("missStalls", 64'({StallF, StallD, StallE, StallM, StallW}), 64'(5'b11111));
        Stall_miss = 0;
        settle();
        checkVal("branchFlushD", 64'(FlushD), 64'(1));
        checkVal("branchFlushE", 64'(FlushE), 64'(1));
        advance();

        // Three busy registers, then asynchronous reset mid-cycle.
        clearInputs();
        LongIssueE = 2'b11; RdE[0 +: RW] = 3; RdE[1*RW +: RW] = 4;
        settle(); advance();
        LongIssueE = 2'b01; RdE = '0; RdE[0 +: RW] = 5;
        settle(); advance();
        checkVal("threeBusy", 64'(BusyCount), 64'(3));
        clearInputs();
        enableD = 1; Rs1D[0 +: RW] = 3;
        settle(); advance();
        #2;
        rst_n = 0;
        #1;
        modelReset();
        checkVal("asyncRstBusy", 64'(BusyCount), 64'(0));
`ifdef HAZARD_PERF_EN
        checkVal("asyncRstPerfSb", 64'(PerfSb), 64'(0));
`endif
        #1;
        rst_n = 1;
        @(negedge clk);
        clearInputs();
        settle();
        checkVal("postRstBusy", 64'(BusyCount), 64'(0));
        advance();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            driveRandom();
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
